// File: rtl/ddr_arb_pkg.sv
// ddr_arb_pkg: shared channel/state encodings and default bus widths for the DDR channel arbiter.
package ddr_arb_pkg;
    localparam int DEF_ADDR_W = 64;
    localparam int DEF_LINE_W = 512;
    typedef enum logic [1:0] {CH_PC, CH_LW, CH_SW} ch_e;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
endpackage

// File: rtl/ddr_channel_arbiter_if.sv
// ddr_channel_arbiter_if: client request/response channels plus the DDR port.
interface ddr_channel_arbiter_if #(
    parameter int ADDR_W = ddr_arb_pkg::DEF_ADDR_W,
    parameter int LINE_W = ddr_arb_pkg::DEF_LINE_W
);
    logic              pc_req, lw_req, sw_req;
    logic [ADDR_W-1:0] pc_index, lw_index, sw_index;
    logic [LINE_W-1:0] sw_write_data;
    logic              pc_done, lw_done, sw_done;
    logic [LINE_W-1:0] pc_read_data, lw_read_data;
    logic              ddr_chip_enable, ddr_write_enable, ddr_burst_mode;
    logic [ADDR_W-1:0] ddr_index;
    logic [LINE_W-1:0] ddr_write_data, ddr_read_data;
    logic              ddr_operation_done, ddr_ready, ddr_timeout_err;
    modport slave (
        input  pc_req, lw_req, sw_req, pc_index, lw_index, sw_index, sw_write_data,
               ddr_read_data, ddr_operation_done, ddr_ready,
        output pc_done, lw_done, sw_done, pc_read_data, lw_read_data,
               ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
               ddr_write_data, ddr_timeout_err
    );
    modport master (
        output pc_req, lw_req, sw_req, pc_index, lw_index, sw_index, sw_write_data,
               ddr_read_data, ddr_operation_done, ddr_ready,
        input  pc_done, lw_done, sw_done, pc_read_data, lw_read_data,
               ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
               ddr_write_data, ddr_timeout_err
    );
endinterface

// File: rtl/ddr_arb_pick.sv
// ddr_arb_pick: fixed priority sw > lw > pc, with pc forced once it has been passed over STARVE_LIM times.
module ddr_arb_pick import ddr_arb_pkg::*; #(
    parameter int STARVE_LIM = 4,
    parameter int CNT_W      = 3
) (
    input  logic [2:0]       reqs,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic [2:0]       gnt,
    output ch_e              ch
);
    logic force_pc;
    always_comb begin
        force_pc = reqs[0] && starve_cnt == CNT_W'(STARVE_LIM);
        gnt = force_pc ? 3'b001 : reqs[2] ? 3'b100 : reqs[1] ? 3'b010 : {2'b00, reqs[0]};
        ch = gnt[2] ? CH_SW : gnt[1] ? CH_LW : CH_PC;
    end
endmodule

// File: rtl/ddr_channel_arbiter.sv
// ddr_channel_arbiter: serialises pc/lw/sw line requests onto one DDR port, one transaction in flight.
module ddr_channel_arbiter import ddr_arb_pkg::*; #(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int LINE_W      = DEF_LINE_W,
    parameter int STARVE_LIM  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input logic                 clock,
    input logic                 reset_n,
    ddr_channel_arbiter_if.slave bus
);
    localparam int SC_W = $clog2(STARVE_LIM + 1);
    localparam int WC_W = $clog2(TIMEOUT_CYC);
    state_e            state;
    ch_e               ch, pick_ch;
    logic [2:0]        gnt;
    logic [SC_W-1:0]   starve_cnt;
    logic [WC_W-1:0]   wait_cnt;
    logic [ADDR_W-1:0] pick_idx;
    logic [LINE_W-1:0] line;
    logic              wait_end;
    ddr_arb_pick #(.STARVE_LIM(STARVE_LIM), .CNT_W(SC_W)) u_pick (
        .reqs({bus.sw_req, bus.lw_req, bus.pc_req}),
        .starve_cnt(starve_cnt),
        .gnt(gnt),
        .ch(pick_ch)
    );
    always_comb begin
        pick_idx = gnt[2] ? bus.sw_index : gnt[1] ? bus.lw_index : bus.pc_index;
        wait_end = bus.ddr_operation_done || wait_cnt == WC_W'(TIMEOUT_CYC - 1);
        line = bus.ddr_operation_done ? bus.ddr_read_data : '0;
    end
    // DDR command fields are loaded at grant and held until the next grant.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ch <= CH_PC;
            starve_cnt <= '0;
            wait_cnt <= '0;
            bus.pc_done <= 1'b0;
            bus.lw_done <= 1'b0;
            bus.sw_done <= 1'b0;
            bus.pc_read_data <= '0;
            bus.lw_read_data <= '0;
            bus.ddr_chip_enable <= 1'b0;
            bus.ddr_index <= '0;
            bus.ddr_write_enable <= 1'b0;
            bus.ddr_burst_mode <= 1'b0;
            bus.ddr_write_data <= '0;
            bus.ddr_timeout_err <= 1'b0;
        end else begin
            bus.pc_done <= 1'b0;
            bus.lw_done <= 1'b0;
            bus.sw_done <= 1'b0;
            bus.ddr_chip_enable <= 1'b0;
            case (state)
                IDLE: if (bus.ddr_ready && |gnt) begin
                    state <= ISSUE;
                    ch <= pick_ch;
                    starve_cnt <= (gnt[0] || !bus.pc_req) ? '0 : starve_cnt + SC_W'(1);
                    bus.ddr_chip_enable <= 1'b1;
                    bus.ddr_index <= pick_idx;
                    bus.ddr_write_enable <= gnt[2];
                    bus.ddr_burst_mode <= gnt[0];
                    bus.ddr_write_data <= bus.sw_write_data;
                end
                ISSUE: begin
                    state <= WAIT;
                    wait_cnt <= '0;
                end
                WAIT: if (wait_end) begin
                    state <= RESP;
                    bus.pc_done <= ch == CH_PC;
                    bus.lw_done <= ch == CH_LW;
                    bus.sw_done <= ch == CH_SW;
                    bus.ddr_timeout_err <= bus.ddr_timeout_err | !bus.ddr_operation_done;
                    if (ch == CH_PC) bus.pc_read_data <= line;
                    if (ch == CH_LW) bus.lw_read_data <= line;
                end else begin
                    wait_cnt <= wait_cnt + WC_W'(1);
                end
                RESP: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_channel_arbiter.sv
// tb_ddr_channel_arbiter: directed stimulus with an issue/response scoreboard checked by a monitor.
module tb_ddr_channel_arbiter;
    import ddr_arb_pkg::*;
    typedef struct {
        ch_e          ch;
        logic [63:0]  idx;
        logic [511:0] wd;
        logic [511:0] rd;
        int           dt;
    } exp_t;
    logic clock, reset_n;
    int n_cmp, n_err, cyc, ddr_lat, issue_cyc;
    exp_t iq[$], rq[$];
    ddr_channel_arbiter_if bus ();
    ddr_channel_arbiter dut (.clock(clock), .reset_n(reset_n), .bus(bus));
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    function automatic logic [511:0] line_of(input logic [63:0] i);
        return {8{i ^ 64'hDEAD_BEEF_0000_0000}};
    endfunction
    function automatic void chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction
    function automatic void miss(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event not expected / not seen", nm);
    endfunction
    function automatic logic done_of(input ch_e c);
        return c == CH_PC ? bus.pc_done : c == CH_LW ? bus.lw_done : bus.sw_done;
    endfunction
    task automatic exp_push(input ch_e c, input logic [63:0] i, input logic [511:0] w,
                            input logic [511:0] r, input int d, input bit resp);
        exp_t e;
        e = '{ch: c, idx: i, wd: w, rd: r, dt: d};
        iq.push_back(e);
        if (resp) rq.push_back(e);
    endtask
    task automatic req_ch(input ch_e c, input logic [63:0] idx, input logic [511:0] wd);
        int n = 0;
        if (c == CH_PC) begin bus.pc_req = 1'b1; bus.pc_index = idx; end
        if (c == CH_LW) begin bus.lw_req = 1'b1; bus.lw_index = idx; end
        if (c == CH_SW) begin bus.sw_req = 1'b1; bus.sw_index = idx; bus.sw_write_data = wd; end
        do begin @(negedge clock); n++; end while (!done_of(c) && n < 3000);
        if (!done_of(c)) miss("req_done_timeout");
        @(posedge clock); #1;
        if (c == CH_PC) bus.pc_req = 1'b0;
        if (c == CH_LW) bus.lw_req = 1'b0;
        if (c == CH_SW) bus.sw_req = 1'b0;
    endtask
    task automatic chk_zero(input string t);
        chk({t, "_ce"}, bus.ddr_chip_enable, 0);
        chk({t, "_index"}, bus.ddr_index, 0);
        chk({t, "_we"}, bus.ddr_write_enable, 0);
        chk({t, "_burst"}, bus.ddr_burst_mode, 0);
        chk({t, "_wdata"}, bus.ddr_write_data, 0);
        chk({t, "_err"}, bus.ddr_timeout_err, 0);
        chk({t, "_dones"}, {bus.sw_done, bus.lw_done, bus.pc_done}, 0);
        chk({t, "_pc_rd"}, bus.pc_read_data, 0);
        chk({t, "_lw_rd"}, bus.lw_read_data, 0);
    endtask
    // DDR model: answers ddr_lat cycles after the ISSUE cycle; ddr_lat <= 0 never answers.
    initial begin
        int cd = -1;
        forever begin
            @(negedge clock);
            if (bus.ddr_chip_enable) cd = ddr_lat > 0 ? ddr_lat : -1;
            @(posedge clock); #1;
            bus.ddr_operation_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    bus.ddr_operation_done = 1'b1;
                    bus.ddr_read_data = line_of(bus.ddr_index);
                    cd = -1;
                end
            end
        end
    end
    initial begin
        exp_t e;
        logic prev_ce = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset_n) prev_ce = 1'b0;
            else begin
                if (bus.ddr_chip_enable) begin
                    chk("ce_pulse", prev_ce, 0);
                    if (!prev_ce && iq.size() == 0) miss("unexpected_issue");
                    else if (!prev_ce) begin
                        e = iq.pop_front();
                        chk("issue_index", bus.ddr_index, e.idx);
                        chk("issue_we", bus.ddr_write_enable, e.ch == CH_SW);
                        chk("issue_burst", bus.ddr_burst_mode, e.ch == CH_PC);
                        if (e.ch == CH_SW) chk("issue_wdata", bus.ddr_write_data, e.wd);
                        issue_cyc = cyc;
                    end
                end
                prev_ce = bus.ddr_chip_enable;
                if ({bus.sw_done, bus.lw_done, bus.pc_done} != 3'b000) begin
                    if (rq.size() == 0) miss("unexpected_done");
                    else begin
                        e = rq.pop_front();
                        chk("done_channel", {bus.sw_done, bus.lw_done, bus.pc_done}, 3'b001 << e.ch);
                        chk("done_latency", cyc - issue_cyc, e.dt);
                        if (e.ch == CH_PC) chk("pc_read_data", bus.pc_read_data, e.rd);
                        if (e.ch == CH_LW) chk("lw_read_data", bus.lw_read_data, e.rd);
                    end
                end
            end
        end
    end
    initial begin
        int n, ce_cnt;
        reset_n = 1'b1;
        {bus.pc_req, bus.lw_req, bus.sw_req, bus.ddr_operation_done} = '0;
        {bus.pc_index, bus.lw_index, bus.sw_index} = '0;
        bus.sw_write_data = '0;
        bus.ddr_read_data = '0;
        bus.ddr_ready = 1'b1;
        ddr_lat = 1;
        #2 reset_n = 1'b0;
        #1 chk_zero("reset");
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        ddr_lat = 5;
        exp_push(CH_LW, 64'h40, '0, line_of(64'h40), 6, 1'b1);
        req_ch(CH_LW, 64'h40, '0);
        ddr_lat = 1;
        exp_push(CH_SW, 64'h100, {64{8'hA5}}, '0, 2, 1'b1);
        exp_push(CH_LW, 64'h140, '0, line_of(64'h140), 2, 1'b1);
        exp_push(CH_PC, 64'h180, '0, line_of(64'h180), 2, 1'b1);
        fork
            req_ch(CH_SW, 64'h100, {64{8'hA5}});
            req_ch(CH_LW, 64'h140, '0);
            req_ch(CH_PC, 64'h180, '0);
        join
        exp_push(CH_SW, 64'h200, {8{64'h200}}, '0, 2, 1'b1);
        exp_push(CH_LW, 64'h210, '0, line_of(64'h210), 2, 1'b1);
        exp_push(CH_SW, 64'h220, {8{64'h220}}, '0, 2, 1'b1);
        exp_push(CH_LW, 64'h230, '0, line_of(64'h230), 2, 1'b1);
        exp_push(CH_PC, 64'h300, '0, line_of(64'h300), 2, 1'b1);
        exp_push(CH_SW, 64'h240, {8{64'h240}}, '0, 2, 1'b1);
        fork
            req_ch(CH_PC, 64'h300, '0);
            begin
                req_ch(CH_SW, 64'h200, {8{64'h200}});
                req_ch(CH_LW, 64'h210, '0);
                req_ch(CH_SW, 64'h220, {8{64'h220}});
                req_ch(CH_LW, 64'h230, '0);
                req_ch(CH_SW, 64'h240, {8{64'h240}});
            end
        join
        bus.ddr_ready = 1'b0;
        exp_push(CH_LW, 64'h280, '0, line_of(64'h280), 2, 1'b1);
        fork
            req_ch(CH_LW, 64'h280, '0);
            begin
                ce_cnt = 0;
                repeat (10) begin @(negedge clock); ce_cnt += int'(bus.ddr_chip_enable); end
                chk("not_ready_ce_count", ce_cnt, 0);
                @(posedge clock); #1 bus.ddr_ready = 1'b1;
                @(negedge clock) chk("ready_rise_ce", bus.ddr_chip_enable, 0);
                @(negedge clock) chk("ready_next_ce", bus.ddr_chip_enable, 1);
            end
        join
        chk("err_before_timeout", bus.ddr_timeout_err, 0);
        ddr_lat = 0;
        exp_push(CH_LW, 64'h500, '0, '0, 1025, 1'b1);
        req_ch(CH_LW, 64'h500, '0);
        chk("timeout_err_set", bus.ddr_timeout_err, 1);
        ddr_lat = 2;
        exp_push(CH_PC, 64'h540, '0, line_of(64'h540), 3, 1'b1);
        req_ch(CH_PC, 64'h540, '0);
        chk("timeout_err_sticky", bus.ddr_timeout_err, 1);
        ddr_lat = 0;
        exp_push(CH_LW, 64'h600, '0, '0, 0, 1'b0);
        bus.lw_req = 1'b1;
        bus.lw_index = 64'h600;
        n = 0;
        do begin @(negedge clock); n++; end while (!bus.ddr_chip_enable && n < 20);
        chk("abort_issue_seen", bus.ddr_chip_enable, 1);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b0;
        #1 chk_zero("abort");
        bus.lw_req = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (5) @(negedge clock);
        ddr_lat = 3;
        exp_push(CH_LW, 64'h640, '0, line_of(64'h640), 4, 1'b1);
        req_ch(CH_LW, 64'h640, '0);
        repeat (5) @(negedge clock);
        chk("issue_queue_left", iq.size(), 0);
        chk("resp_queue_left", rq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
